// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit common-anode 7-segment
//   display. Each digit owns a slot of REFRESH_DIV cycles. The first
//   BLANK_CYCLES cycles of every slot keep all anodes off, which suppresses
//   ghosting. The remaining cycles drive the slot's anode. The digit value,
//   the adjust-blink flag and the colon flag are latched at the start of each
//   slot, so input changes take effect only from the next slot.
//
// Ports
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   out1     1 Hz blink level, synchronous to clk
//   adj      adjust mode enable
//   adj_sel  field under adjustment: 0 = minutes, 1 = seconds
//   run      stopwatch is counting
//   min_l, min_r, sec_l, sec_r   digit values (0-9 valid, others blank)
//   an       anode enables, active-low (an[3] = min_l ... an[0] = sec_r)
//   seg      segments {g,f,e,d,c,b,a}, active-low
//   dp       colon decimal point, active-low
module display_scan_ctrl #(
  parameter int REFRESH_DIV  = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       out1,
  input  logic       adj,
  input  logic       adj_sel,
  input  logic       run,
  input  logic [4:0] min_l,
  input  logic [4:0] min_r,
  input  logic [4:0] sec_l,
  input  logic [4:0] sec_r,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [4:0]    slot_val_q, slot_val_d;
  logic          slot_blank_q, slot_blank_d;
  logic          slot_dp_q, slot_dp_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic [4:0]    digit_sel;
  logic          in_field;
  logic          blank_flag;
  logic          dp_flag;
  logic [3:0]    an_drive;

  function automatic logic [6:0] seg_decode(input logic [4:0] v);
    logic [6:0] s;
    case (v)
      5'd0:    s = 7'b1000000;
      5'd1:    s = 7'b1111001;
      5'd2:    s = 7'b0100100;
      5'd3:    s = 7'b0110000;
      5'd4:    s = 7'b0011001;
      5'd5:    s = 7'b0010010;
      5'd6:    s = 7'b0000010;
      5'd7:    s = 7'b1111000;
      5'd8:    s = 7'b0000000;
      5'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Digit selected by the current slot index.
  always_comb begin
    digit_sel = min_l;
    case (idx_q)
      2'd0: digit_sel = min_l;
      2'd1: digit_sel = min_r;
      2'd2: digit_sel = sec_l;
      2'd3: digit_sel = sec_r;
      default: digit_sel = min_l;
    endcase
  end

  // idx[1] separates minutes (slots 0,1) from seconds (slots 2,3).
  assign in_field   = adj_sel ? idx_q[1] : ~idx_q[1];
  assign blank_flag = adj & ~out1 & in_field;
  // Colon sits after min_r: lit (0) when stopped, or on the high blink phase.
  assign dp_flag    = (idx_q == 2'd1) ? (run & ~out1) : 1'b1;

  // One-cold anode pattern: anode (3-idx) is the active digit.
  for (genvar gi = 0; gi < 4; gi++) begin : g_anode
    assign an_drive[gi] = (idx_q != 2'(3 - gi));
  end

  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    slot_val_d   = slot_val_q;
    slot_blank_d = slot_blank_q;
    slot_dp_d    = slot_dp_q;
    an_d         = 4'b1111;
    seg_d        = 7'b1111111;
    dp_d         = 1'b1;

    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (cnt_q == '0) begin
      slot_val_d   = digit_sel;
      slot_blank_d = blank_flag;
      slot_dp_d    = dp_flag;
    end

    // Slot registers are already loaded by the first DRIVE cycle because
    // BLANK_CYCLES >= 1 keeps cnt==0 inside the guard phase.
    if (cnt_q >= CNT_BLANK) begin
      an_d  = an_drive;
      seg_d = slot_blank_q ? 7'b1111111 : seg_decode(slot_val_q);
      dp_d  = slot_dp_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      slot_val_q   <= 5'd0;
      slot_blank_q <= 1'b0;
      slot_dp_q    <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      slot_val_q   <= slot_val_d;
      slot_blank_q <= slot_blank_d;
      slot_dp_q    <= slot_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * RD;
  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       out1 = 1'b0, adj = 1'b0, adj_sel = 1'b0, run = 1'b0;
  logic [4:0] min_l = 5'd0, min_r = 5'd0, sec_l = 5'd0, sec_r = 5'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  display_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .out1(out1), .adj(adj), .adj_sel(adj_sel),
    .run(run), .min_l(min_l), .min_r(min_r), .sec_l(sec_l), .sec_r(sec_r),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // Reference model: p = rising edges since reset release. The state seen at
  // edge p+1 is slot (p/RD)%4 at position p%RD; outputs after that edge
  // reflect it. Slot contents are snapshotted at position 0.
  int         p = 0;
  logic [4:0] m_val = 5'd0;
  bit         m_blank = 1'b0;
  bit         m_dp = 1'b0;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  task automatic model_step();
    int c, i;
    logic [4:0] d [4];
    c = p % RD;
    i = (p / RD) % 4;
    d = '{min_l, min_r, sec_l, sec_r};
    if (c == 0) begin
      m_val   = d[i];
      m_blank = adj && !out1 && (adj_sel ? (i >= 2) : (i < 2));
      m_dp    = (i == 1) ? (run && !out1) : 1'b1;
    end
    if (c < BC) begin
      exp_an = 4'b1111; exp_seg = 7'b1111111; exp_dp = 1'b1;
    end else begin
      exp_an  = 4'b1111;
      exp_an[3 - i] = 1'b0;
      exp_seg = (m_blank || m_val > 9) ? 7'b1111111 : SEG_TAB[m_val];
      exp_dp  = m_dp;
    end
    @(posedge clk);
    #1;
    p++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL reset_an got=%b exp=1111", an); end
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL reset_seg got=%b exp=1111111", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp); end
    @(negedge clk);
    rst_n = 1'b1;
    p = 0;
    $display("reset released");
  endtask

  task automatic test_scan();
    min_l = 5'd1; min_r = 5'd2; sec_l = 5'd3; sec_r = 5'd4;
    adj = 1'b0; run = 1'b0; out1 = 1'b0;
    for (int n = 0; n < 2 * FRAME; n++) begin
      model_step();
      checks++; if (an !== exp_an) begin errors++; $display("FAIL scan_an p=%0d got=%b exp=%b", p, an, exp_an); end
      checks++; if (seg !== exp_seg) begin errors++; $display("FAIL scan_seg p=%0d got=%b exp=%b", p, seg, exp_seg); end
      checks++; if (dp !== exp_dp) begin errors++; $display("FAIL scan_dp p=%0d got=%b exp=%b", p, dp, exp_dp); end
      // Fixed anchor points from the timing rules, independent of the model.
      if (p == BC) begin
        checks++; if (an !== 4'b1111) begin errors++; $display("FAIL scan_guard got=%b exp=1111", an); end
      end
      if (p == BC + 1) begin
        checks++; if (an !== 4'b0111 || seg !== 7'b1111001) begin errors++; $display("FAIL scan_first an=%b seg=%b exp=0111/1111001", an, seg); end
      end
    end
    $display("scan: 2 frames done p=%0d", p);
  endtask

  task automatic test_adjust();
    adj = 1'b1; adj_sel = 1'b1; out1 = 1'b0;
    for (int n = 0; n < 2 * FRAME; n++) begin
      if (n == FRAME) out1 = 1'b1;
      model_step();
      checks++; if (an !== exp_an) begin errors++; $display("FAIL adjust_an p=%0d got=%b exp=%b", p, an, exp_an); end
      checks++; if (seg !== exp_seg) begin errors++; $display("FAIL adjust_seg p=%0d got=%b exp=%b", p, seg, exp_seg); end
      checks++; if (dp !== exp_dp) begin errors++; $display("FAIL adjust_dp p=%0d got=%b exp=%b", p, dp, exp_dp); end
    end
    adj = 1'b0; out1 = 1'b0;
    $display("adjust: blink and show frames done p=%0d", p);
  endtask

  task automatic test_midslot();
    sec_r = 5'd4;
    while ((p % FRAME) != 3 * RD + 4) begin
      model_step();
      checks++; if (seg !== exp_seg) begin errors++; $display("FAIL midslot_pre p=%0d got=%b exp=%b", p, seg, exp_seg); end
    end
    sec_r = 5'd7;
    for (int n = 0; n < FRAME + RD; n++) begin
      model_step();
      checks++; if (an !== exp_an) begin errors++; $display("FAIL midslot_an p=%0d got=%b exp=%b", p, an, exp_an); end
      checks++; if (seg !== exp_seg) begin errors++; $display("FAIL midslot_seg p=%0d got=%b exp=%b", p, seg, exp_seg); end
      if (n == 1) begin
        checks++; if (seg !== 7'b0011001) begin errors++; $display("FAIL midslot_hold got=%b exp=0011001", seg); end
      end
    end
    $display("midslot: sec_r change done p=%0d", p);
  endtask

  task automatic test_colon();
    run = 1'b1;
    for (int n = 0; n < 3 * FRAME; n++) begin
      if (n % 13 == 0) out1 = ~out1;
      if (n == 2 * FRAME) run = 1'b0;
      model_step();
      checks++; if (dp !== exp_dp) begin errors++; $display("FAIL colon_dp p=%0d got=%b exp=%b", p, dp, exp_dp); end
      checks++; if (an !== exp_an) begin errors++; $display("FAIL colon_an p=%0d got=%b exp=%b", p, an, exp_an); end
    end
    out1 = 1'b0;
    $display("colon: run/stop frames done p=%0d", p);
  endtask

  task automatic test_invalid();
    min_l = 5'd12;
    for (int n = 0; n < 2 * FRAME; n++) begin
      model_step();
      checks++; if (seg !== exp_seg) begin errors++; $display("FAIL invalid_seg p=%0d got=%b exp=%b", p, seg, exp_seg); end
      checks++; if (an !== exp_an) begin errors++; $display("FAIL invalid_an p=%0d got=%b exp=%b", p, an, exp_an); end
    end
    $display("invalid: min_l=12 frames done p=%0d", p);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        min_l = 5'($urandom_range(0, 31)); min_r = 5'($urandom_range(0, 11));
        sec_l = 5'($urandom_range(0, 11)); sec_r = 5'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 7) == 0) out1 = ~out1;
      if ($urandom_range(0, 15) == 0) adj = 1'($urandom);
      if ($urandom_range(0, 15) == 0) adj_sel = 1'($urandom);
      if ($urandom_range(0, 15) == 0) run = 1'($urandom);
      model_step();
      checks++; if (an !== exp_an) begin errors++; $display("FAIL random_an p=%0d got=%b exp=%b", p, an, exp_an); end
      checks++; if (seg !== exp_seg) begin errors++; $display("FAIL random_seg p=%0d got=%b exp=%b", p, seg, exp_seg); end
      checks++; if (dp !== exp_dp) begin errors++; $display("FAIL random_dp p=%0d got=%b exp=%b", p, dp, exp_dp); end
    end
    $display("random: 400 cycles done p=%0d", p);
  endtask

  task automatic test_async_reset();
    min_l = 5'd5; min_r = 5'd6; sec_l = 5'd8; sec_r = 5'd9;
    adj = 1'b0; run = 1'b1; out1 = 1'b0;
    while ((p % RD) != 5) model_step();
    checks++; if (an === 4'b1111) begin errors++; $display("FAIL async_pre an=%b exp=one-cold", an); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (an !== 4'b1111) begin errors++; $display("FAIL async_an got=%b exp=1111", an); end
    checks++; if (seg !== 7'b1111111) begin errors++; $display("FAIL async_seg got=%b exp=1111111", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL async_dp got=%b exp=1", dp); end
    @(negedge clk);
    rst_n = 1'b1;
    p = 0;
    for (int n = 0; n < FRAME; n++) begin
      model_step();
      checks++; if (an !== exp_an) begin errors++; $display("FAIL async_restart_an p=%0d got=%b exp=%b", p, an, exp_an); end
      checks++; if (seg !== exp_seg) begin errors++; $display("FAIL async_restart_seg p=%0d got=%b exp=%b", p, seg, exp_seg); end
    end
    $display("async reset: restart frame done p=%0d", p);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_adjust();
    test_midslot();
    test_colon();
    test_invalid();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
